// File: rtl/jvm_arm_xlate.sv
// Streaming Java-bytecode to A32 translator: byte-stream in, ARM words out through an output FIFO.
// Build option: define JAA_UNSUPPORTED_TRAP_EN to trap (sticky err, input halted) on unsupported opcodes.
module jvm_arm_xlate #(
   parameter int FIFO_DEPTH = 8,
   parameter int LOCALS_REG = 3,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [7:0]           in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [31:0]          out_data,
   input  logic                 out_ready,
   output logic                 busy,
   output logic                 err,
   output logic [CNT_WIDTH-1:0] op_count,
   output logic [CNT_WIDTH-1:0] word_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [3:0]  LREG = 4'(LOCALS_REG);
   localparam logic [31:0] BASE = {12'h000, LREG, 16'h0000};
   localparam logic [31:0] PUSH_R1  = 32'hE92D0002;
   localparam logic [31:0] POP_R1   = 32'hE8BD0002;
   localparam logic [31:0] POP_R1R2 = 32'hE8BD0006;

   typedef enum logic [1:0] {FETCH_OP, FETCH_OP1, FETCH_OP2, EMIT} state_t;

   typedef struct packed {
      logic       ok;
      logic [1:0] nops;
      logic [1:0] nwords;
   } dec_t;

   function automatic dec_t decode(input logic [7:0] op);
      dec_t d;
      d = '0;
      d.ok = 1'b1;
      case (op) inside
         8'h00:                             d.nwords = 2'd0;
         [8'h02:8'h08], [8'h1A:8'h1D],
         [8'h3B:8'h3E], 8'h59:              d.nwords = 2'd2;
         8'h10, 8'h15, 8'h36:               begin d.nops = 2'd1; d.nwords = 2'd2; end
         8'h11:                             begin d.nops = 2'd2; d.nwords = 2'd2; end
         8'h57:                             d.nwords = 2'd1;
         8'h60, 8'h64:                      d.nwords = 2'd3;
         default:                           d.ok = 1'b0;
      endcase
      return d;
   endfunction

   // Local-variable byte offset lands in the 12-bit immediate field.
   function automatic logic [31:0] loc_off(input logic [7:0] n);
      return {22'h0, n, 2'b00};
   endfunction

   function automatic logic [31:0] arm_word(input logic [7:0] op, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [1:0] idx);
      logic [2:0][31:0] w;
      w = '0;
      case (op) inside
         8'h02: begin w[0] = 32'hE3E01000; w[1] = PUSH_R1; end
         [8'h03:8'h08]: begin w[0] = 32'hE3A01000 | 32'(op - 8'h03); w[1] = PUSH_R1; end
         8'h10: begin
            w[0] = b1[7] ? {24'hE3E010, ~b1} : {24'hE3A010, b1};
            w[1] = PUSH_R1;
         end
         8'h11: begin
            if (!b1[7]) begin
               w[0] = {24'hE3A010, b2};
               w[1] = {24'hE3811C, b1};
            end else begin
               w[0] = {24'hE3E010, ~b2};
               w[1] = {24'hE3C11C, ~b1};
            end
         end
         8'h15: begin w[0] = 32'hE5901000 | BASE | loc_off(b1); w[1] = PUSH_R1; end
         [8'h1A:8'h1D]: begin
            w[0] = 32'hE5901000 | BASE | loc_off(op - 8'h1A);
            w[1] = PUSH_R1;
         end
         8'h36: begin w[0] = POP_R1; w[1] = 32'hE5801000 | BASE | loc_off(b1); end
         [8'h3B:8'h3E]: begin
            w[0] = POP_R1;
            w[1] = 32'hE5801000 | BASE | loc_off(op - 8'h3B);
         end
         8'h57: w[0] = 32'hE28DD004;
         8'h59: begin w[0] = 32'hE59D1000; w[1] = PUSH_R1; end
         8'h60: begin w[0] = POP_R1R2; w[1] = 32'hE0811002; w[2] = PUSH_R1; end
         8'h64: begin w[0] = POP_R1R2; w[1] = 32'hE0421001; w[2] = PUSH_R1; end
         default: w = '0;
      endcase
      return w[idx];
   endfunction

   state_t         state, state_n;
   logic [7:0]     opc, op1, op2;
   logic [1:0]     widx, widx_n;
   logic           accept, push, pop, full, op_done;
   logic [7:0]     dec_op;
   dec_t           dec;
   logic [31:0]    word;

   logic [31:0]    mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [AW:0]    cnt;

`ifdef JAA_UNSUPPORTED_TRAP_EN
   logic err_q, err_set;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // In FETCH_OP the opcode is decoded straight off the input byte; later states use the latched one.
   assign dec_op = (state == FETCH_OP) ? in_data : opc;
   assign dec    = decode(dec_op);
   assign word   = arm_word(opc, op1, op2, widx);

   assign full      = (cnt == (AW+1)'(FIFO_DEPTH));
   assign out_valid = (cnt != '0);
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign pop       = out_valid && out_ready;
   assign busy      = (state != FETCH_OP) || out_valid;

   always_comb begin
      state_n  = state;
      widx_n   = widx;
      push     = 1'b0;
      op_done  = 1'b0;
`ifdef JAA_UNSUPPORTED_TRAP_EN
      err_set  = 1'b0;
      in_ready = !reset && (state != EMIT) && !err_q;
`else
      in_ready = !reset && (state != EMIT);
`endif
      accept   = in_valid && in_ready;
      case (state)
         FETCH_OP: if (accept) begin
            if (!dec.ok) begin
`ifdef JAA_UNSUPPORTED_TRAP_EN
               err_set = 1'b1;
`endif
            end else if (dec.nops != 2'd0) begin
               state_n = FETCH_OP1;
            end else if (dec.nwords == 2'd0) begin
               op_done = 1'b1;
            end else begin
               state_n = EMIT;
            end
         end
         FETCH_OP1: if (accept) state_n = (opc == 8'h11) ? FETCH_OP2 : EMIT;
         FETCH_OP2: if (accept) state_n = EMIT;
         EMIT: if (!full) begin
            push = 1'b1;
            if (widx == dec.nwords - 2'd1) begin
               state_n = FETCH_OP;
               widx_n  = 2'd0;
               op_done = 1'b1;
            end else begin
               widx_n = widx + 2'd1;
            end
         end
         default: state_n = FETCH_OP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= FETCH_OP;
         widx       <= 2'd0;
         opc        <= '0;
         op1        <= '0;
         op2        <= '0;
         op_count   <= '0;
         word_count <= '0;
`ifdef JAA_UNSUPPORTED_TRAP_EN
         err_q      <= 1'b0;
`endif
      end else begin
         state <= state_n;
         widx  <= widx_n;
         if (accept) begin
            case (state)
               FETCH_OP:  opc <= in_data;
               FETCH_OP1: op1 <= in_data;
               FETCH_OP2: op2 <= in_data;
               default:   ;
            endcase
         end
         if (op_done) op_count   <= op_count + 1'b1;
         if (push)    word_count <= word_count + 1'b1;
`ifdef JAA_UNSUPPORTED_TRAP_EN
         if (err_set) err_q <= 1'b1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage is not reset; out_data is masked by out_valid instead.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= word;
   end

endmodule

// File: tb/tb_jvm_arm_xlate.sv
// Directed bench for jvm_arm_xlate: expected ARM words are queued at stimulus time and checked on output.
module tb_jvm_arm_xlate;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        out_ready = 1'b0;
   logic        in_ready, out_valid, busy, err;
   logic [31:0] out_data;
   logic [15:0] op_count, word_count;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   jvm_arm_xlate #(.FIFO_DEPTH(8), .LOCALS_REG(3), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .busy(busy), .err(err), .op_count(op_count), .word_count(word_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Output monitor: every popped word must match the head of the expectation queue.
   always @(negedge clk) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) chk("out_unexpected", 32'(exp_q.size()), 32'd1);
         else                   chk("out_word", out_data, exp_q.pop_front());
      end
   end

   task automatic send(input logic [7:0] b);
      int n = 0;
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) chk("send_timeout", 32'(n), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy !== 1'b0 && n < 300) begin
         n++;
         @(negedge clk);
      end
      chk("idle_timeout", 32'(busy), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int acc;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_in_ready_rel", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_op_count", 32'(op_count), 32'd0);
      chk("rst_word_count", 32'(word_count), 32'd0);
      @(posedge clk); #1;

      // iconst_1, istore_1
      out_ready = 1'b1;
      exp_q.push_back(32'hE3A01001); exp_q.push_back(32'hE92D0002);
      exp_q.push_back(32'hE8BD0002); exp_q.push_back(32'hE5831004);
      send(8'h04); send(8'h3C);
      wait_idle();
      chk("t1_op_count", 32'(op_count), 32'd2);
      chk("t1_word_count", 32'(word_count), 32'd4);

      // sipush negative and positive
      exp_q.push_back(32'hE3E010F3); exp_q.push_back(32'hE3C11C01);
      exp_q.push_back(32'hE3A0102C); exp_q.push_back(32'hE3811C01);
      send(8'h11); send(8'hFE); send(8'h0C);
      send(8'h11); send(8'h01); send(8'h2C);
      wait_idle();

      // bipush -128, iload 255
      exp_q.push_back(32'hE3E0107F); exp_q.push_back(32'hE92D0002);
      exp_q.push_back(32'hE59313FC); exp_q.push_back(32'hE92D0002);
      send(8'h10); send(8'h80);
      send(8'h15); send(8'hFF);
      wait_idle();
      chk("t3_op_count", 32'(op_count), 32'd6);

      // iadd x3 against a stalled sink: FIFO fills, 9th word held in EMIT
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(32'hE8BD0006); exp_q.push_back(32'hE0811002);
         exp_q.push_back(32'hE92D0002);
      end
      send(8'h60); send(8'h60); send(8'h60);
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_word_count", 32'(word_count), 32'd20);
      chk("bp_op_count", 32'(op_count), 32'd8);
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_idle();
      chk("bp_drained", 32'(exp_q.size()), 32'd0);
      chk("bp_op_final", 32'(op_count), 32'd9);
      chk("bp_word_final", 32'(word_count), 32'd21);

      // Unsupported opcode FF followed by iconst_0
`ifdef JAA_UNSUPPORTED_TRAP_EN
      send(8'hFF);
      in_valid = 1'b1;
      in_data  = 8'h03;
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (in_ready !== 1'b0) acc++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("trap_no_accept", 32'(acc), 32'd0);
      chk("trap_err", 32'(err), 32'd1);
      chk("trap_op_count", 32'(op_count), 32'd9);
      chk("trap_word_count", 32'(word_count), 32'd21);
`else
      acc = 0;
      exp_q.push_back(32'hE3A01000); exp_q.push_back(32'hE92D0002);
      send(8'hFF); send(8'h03);
      wait_idle();
      chk("skip_err", 32'(err), 32'd0);
      chk("skip_op_count", 32'(op_count), 32'd10);
      chk("skip_word_count", 32'(word_count), 32'd23);
      chk("skip_acc", 32'(acc), 32'd0);
`endif

      // Reset during the second word of isub, then dup
      out_ready = 1'b0;
      send(8'h64);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_op_count", 32'(op_count), 32'd0);
      chk("mid_rst_word_count", 32'(word_count), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_err", 32'(err), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      out_ready = 1'b1;
      exp_q.push_back(32'hE59D1000); exp_q.push_back(32'hE92D0002);
      send(8'h59);
      wait_idle();
      chk("dup_op_count", 32'(op_count), 32'd1);
      chk("dup_word_count", 32'(word_count), 32'd2);
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/jvm_arm_xlate.md
Name: jvm_arm_xlate

Overview:
- Streaming Java-bytecode to ARM (A32) translator: the next generation of the single-opcode translator.
- Consumes a byte stream of bytecodes and operands over a valid/ready handshake; emits 32-bit ARM words through a parametrised output FIFO with valid/ready.
- Adds operand-bearing opcodes, backpressure and an op/word counter. Sits between the bytecode ROM reader and the instruction sink (file writer or downstream core).

Parameters:
- FIFO_DEPTH, 8, output FIFO entries; power of 2, at least 4.
- LOCALS_REG, 3, 4-bit ARM register index holding the locals base (field B below).
- CNT_WIDTH, 16, width of op_count and word_count.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  in_data holds a bytecode byte.
- in_data  in  8  bytecode or operand byte.
- in_ready  out  1  byte accepted when in_valid&in_ready at posedge.
- out_valid  out  1  FIFO non-empty.
- out_data  out  32  FIFO head ARM word.
- out_ready  in  1  head popped when out_valid&out_ready.
- busy  out  1  state != FETCH_OP or FIFO non-empty.
- err  out  1  sticky unsupported-opcode flag (see Optional Feature).
- op_count  out  CNT_WIDTH  opcodes fully translated; wraps.
- word_count  out  CNT_WIDTH  ARM words written into FIFO; wraps.

Behaviour:
- Reset: state=FETCH_OP, FIFO empty, in_ready=0 during reset then 1, out_valid=0, out_data=0, busy=0, err=0, counters=0. Reset mid-emit drops the pending sequence and FIFO contents.
- States: FETCH_OP -> FETCH_OP1 (1- or 2-operand op) or EMIT (0-operand). FETCH_OP1 -> FETCH_OP2 (sipush) or EMIT. FETCH_OP2 -> EMIT. EMIT -> FETCH_OP after the last word; op_count++ on that cycle.
- in_ready=1 only in FETCH_* states.
- EMIT writes one word per cycle in table order. It stalls without skipping while the FIFO is full. Full is evaluated before the same-cycle pop; there is no pass-through.
- Latency: the opcode is accepted at cycle 0, the first word is written at cycle 1, and out_valid rises at cycle 2.
- Register use is fixed: r1 and r2 are scratch, sp is the Java operand stack. B = LOCALS_REG<<16. n = local index; the offset is n*4 (12-bit field).
- Word table (hex):
  - nop 00: none.
  - iconst_m1 02: E3E01000, E92D0002.
  - iconst_0..5 03..08: E3A0100k, E92D0002.
  - bipush 10 b: if b[7]=0, E3A010bb; else E3E010(~b); then E92D0002.
  - sipush 11 hi lo: if hi[7]=0, E3A010lo and E3811C(hi); else E3E010(~lo) and E3C11C(~hi).
  - iload 15 n, iload_0..3 1A..1D: E5901000|B|n*4, E92D0002.
  - istore 36 n, istore_0..3 3B..3E: E8BD0002, E5801000|B|n*4.
  - pop 57: E28DD004.
  - dup 59: E59D1000, E92D0002.
  - iadd 60: E8BD0006, E0811002, E92D0002.
  - isub 64: E8BD0006, E0421001, E92D0002.
- Maximum sequence is 3 words.
- word_count increments on each FIFO write. Both counters wrap modulo 2^CNT_WIDTH.
- FIFO: pointer wrap modulo FIFO_DEPTH. Simultaneous push and pop on a non-full FIFO keeps the occupancy constant.

Optional Feature:
- Macro JAA_UNSUPPORTED_TRAP_EN.
- Defined: an unsupported opcode sets err. The state then holds in FETCH_OP with in_ready=0 until reset. The FIFO still drains.
- Undefined: an unsupported opcode is consumed and skipped, with no words and no op_count increment. err is tied to 0.

Test Plan:
- Stream 04,3C (iconst_1, istore_1) with out_ready=1 -> E3A01001, E92D0002, E8BD0002, E5831004; op_count=2, word_count=4.
- sipush 11 FE 0C -> E3E010F3, E3C11C01; sipush 11 01 2C -> E3A0102C, E3811C01.
- bipush 10 80 then iload 15 FF -> E3E0107F, E92D0002, E59313FC, E92D0002.
- out_ready=0, feed iadd x3 (9 words, FIFO_DEPTH=8) -> 8 words queued, in_ready=0, state stuck in EMIT. Raising out_ready delivers all 9 words in order with none lost.
- Opcode FF then 03: with the macro, err=1, in_ready=0 and 03 is never consumed. Without the macro, FF is skipped and the output is E3A01000, E92D0002.
- Assert reset during the second word of isub -> next cycle out_valid=0, counters=0. Then feed 59 -> E59D1000, E92D0002.
